// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared types for the fetch-stage controller: FSM encoding and register index constants.
package fetch_ctrl_pkg;
   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } fsm_t;
endpackage

// File: rtl/fetch_hazard_ctrl_hazard_detect.sv
// Load-use and jr-operand hazard detection; purely combinational, 0-cycle latency.
// No flow control; register $zero never matches.
module hazard_detect #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_jr,
   input  logic              ex_memread,
   input  logic              ex_regwrite,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_rd,
   output logic              lu_haz,
   output logic              jr_haz,
   output logic              stall
);
   import fetch_ctrl_pkg::*;

   logic ex_nz;
   logic mem_nz;

   assign ex_nz  = (ex_rd != REG_AW'(ZERO_REG));
   assign mem_nz = (mem_rd != REG_AW'(ZERO_REG));

   assign lu_haz = ex_memread && ex_nz &&
                   ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

   // jr reads rs in ID, so it must also wait out a load sitting in MEM.
   assign jr_haz = id_jr &&
                   ((ex_regwrite && ex_nz && id_rs == ex_rd) ||
                    (mem_memread && mem_nz && id_rs == mem_rd));

   assign stall = lu_haz || jr_haz;
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch/front-end sequencer: redirect priority, hazard stalls, halt/drain/resume; 0-cycle control latency.
// Stalls hold PC and IF/ID; FETCH_HAZARD_CTRL_PERF_EN adds stall/redirect counters.
module fetch_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_jmp,
   input  logic              id_jr,
   input  logic              ex_memread,
   input  logic              ex_regwrite,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              ex_branch_taken,
   input  logic              halt_req,
   input  logic              resume,
   output logic              pc_en,
   output logic              fe_jmp,
   output logic              fe_jr,
   output logic              fe_branch,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              halted,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);
   import fetch_ctrl_pkg::*;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   fsm_t       state;
   logic [3:0] drain_cnt;
   logic       lu_haz;
   logic       jr_haz;
   logic       stall;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_jr       (id_jr),
      .ex_memread  (ex_memread),
      .ex_regwrite (ex_regwrite),
      .ex_rd       (ex_rd),
      .mem_memread (mem_memread),
      .mem_rd      (mem_rd),
      .lu_haz      (lu_haz),
      .jr_haz      (jr_haz),
      .stall       (stall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_INIT;
               end
            end
            DRAIN: begin
               if (drain_cnt == 4'd0) state <= HALT;
               else                   drain_cnt <= drain_cnt - 4'd1;
            end
            HALT: begin
               if (resume) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      pc_en      = 1'b0;
      fe_jmp     = 1'b0;
      fe_jr      = 1'b0;
      fe_branch  = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      if (rst) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else begin
         case (state)
            RUN: begin
               // A taken branch makes everything younger wrong-path, so it beats stalls and ID jumps.
               if (ex_branch_taken) begin
                  fe_branch  = 1'b1;
                  pc_en      = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (stall) begin
                  idex_flush = 1'b1;
               end else if (id_jmp) begin
                  fe_jmp     = 1'b1;
                  pc_en      = 1'b1;
                  ifid_flush = 1'b1;
               end else if (id_jr) begin
                  fe_jr      = 1'b1;
                  pc_en      = 1'b1;
                  ifid_flush = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
               end
            end
            DRAIN: begin
               ifid_flush = 1'b1;
               idex_flush = stall || ex_branch_taken;
               if (ex_branch_taken) begin
                  fe_branch = 1'b1;
                  pc_en     = 1'b1;
               end
            end
            HALT: begin
               halted     = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end
            default: begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;
   logic        run_stall;

   assign run_stall = (state == RUN) && !ex_branch_taken && stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (run_stall)                    stall_q <= stall_q + 32'd1;
         if (fe_jmp || fe_jr || fe_branch) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed-vector bench for fetch_hazard_ctrl with a queue-based scoreboard checked on the falling edge.
module tb_fetch_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_use_rs, id_use_rt, id_jmp, id_jr;
   logic       ex_memread, ex_regwrite, mem_memread, ex_branch_taken;
   logic       halt_req, resume;
   logic       pc_en, fe_jmp, fe_jr, fe_branch, ifid_en, ifid_flush, idex_flush, halted;
   logic [31:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   fetch_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_jmp(id_jmp), .id_jr(id_jr),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
      .mem_memread(mem_memread), .mem_rd(mem_rd),
      .ex_branch_taken(ex_branch_taken), .halt_req(halt_req), .resume(resume),
      .pc_en(pc_en), .fe_jmp(fe_jmp), .fe_jr(fe_jr), .fe_branch(fe_branch),
      .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // {pc_en, fe_jmp, fe_jr, fe_branch, ifid_en, ifid_flush, idex_flush, halted}
   logic [7:0] obs;
   assign obs = {pc_en, fe_jmp, fe_jr, fe_branch, ifid_en, ifid_flush, idex_flush, halted};

   localparam logic [7:0] NORM = 8'h88, STL = 8'h02, RSTV = 8'h06, BR = 8'h96;
   localparam logic [7:0] JMP  = 8'hC4, JR  = 8'hA4, DRN  = 8'h04, HLT = 8'h07;
   localparam logic [7:0] FULL = 8'hFF, M_BR = 8'hF7, M_J = 8'hF5;

`ifdef FETCH_HAZARD_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [7:0]  exp;
      logic [7:0]  mask;
      bit          cchk;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [31:0] pcnt(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic expect_o(input string name, input logic [7:0] e, input logic [7:0] m);
      exp_t x;
      x.name = name; x.exp = e; x.mask = m; x.cchk = 1'b0; x.sc = '0; x.fc = '0;
      q.push_back(x);
   endtask

   task automatic expect_c(input string name, input logic [7:0] e, input logic [7:0] m,
                           input int sc, input int fc);
      exp_t x;
      x.name = name; x.exp = e; x.mask = m; x.cchk = 1'b1; x.sc = pcnt(sc); x.fc = pcnt(fc);
      q.push_back(x);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
      id_use_rs = 0; id_use_rt = 0; id_jmp = 0; id_jr = 0;
      ex_memread = 0; ex_regwrite = 0; mem_memread = 0; ex_branch_taken = 0;
      halt_req = 0; resume = 0;
   endtask

   task automatic load_use_rs8;
      ex_memread = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1;
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         cur = q.pop_front();
         n_cmp++;
         if ((obs & cur.mask) !== (cur.exp & cur.mask)) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b (care %b)", cur.name, obs, cur.exp, cur.mask);
         end
         if (cur.cchk) begin
            n_cmp++;
            if (stall_cnt !== cur.sc || flush_cnt !== cur.fc) begin
               n_bad++;
               $display("FAIL %s_cnt: stall/flush got %0d/%0d want %0d/%0d",
                        cur.name, stall_cnt, flush_cnt, cur.sc, cur.fc);
            end
         end
      end
   end

   initial begin
      idle(); rst = 1'b1;
      tick();
      expect_o("reset0", RSTV, FULL); tick();
      expect_o("reset1", RSTV, FULL); tick();
      rst = 1'b0;
      expect_c("run_idle", NORM, FULL, 0, 0); tick();

      // load-use on rs, then load moves to MEM
      idle(); load_use_rs8(); expect_o("lu_rs", STL, FULL); tick();
      idle(); mem_memread = 1; mem_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1;
      expect_o("lu_release", NORM, FULL); tick();

      // load-use on rt, then the same indices without the use flag
      idle(); ex_memread = 1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1;
      expect_o("lu_rt", STL, FULL); tick();
      id_use_rt = 0; expect_o("lu_rt_unused", NORM, FULL); tick();

      // $zero never creates a hazard
      idle(); ex_memread = 1; id_use_rs = 1; expect_o("lu_zero", NORM, FULL); tick();

      // jr after load: stall with load in EX, stall with load in MEM, then redirect
      idle(); id_jr = 1; id_rs = 5'd31; id_use_rs = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd31;
      expect_o("jr_stall_ex", STL, FULL); tick();
      ex_memread = 0; ex_regwrite = 0; ex_rd = 5'd0; mem_memread = 1; mem_rd = 5'd31;
      expect_o("jr_stall_mem", STL, FULL); tick();
      mem_memread = 0; mem_rd = 5'd0;
      expect_o("jr_go", JR, M_J); tick();

      idle(); id_jr = 1; ex_regwrite = 1; mem_memread = 1;
      expect_o("jr_zero", JR, M_J); tick();

      // branch beats jump and load-use together
      idle(); ex_branch_taken = 1; id_jmp = 1; load_use_rs8();
      expect_o("prio_branch", BR, M_BR); tick();
      idle(); id_jmp = 1; expect_o("jmp", JMP, M_J); tick();
      idle(); expect_c("perf_mid", NORM, FULL, 4, 4); tick();

      // halt/drain/resume
      idle(); halt_req = 1; expect_o("halt_req_run", NORM, FULL); tick();
      idle(); ex_branch_taken = 1; expect_o("drain_branch", 8'h94, M_J); tick();
      idle(); id_jmp = 1; expect_o("drain_jmp_ignored", DRN, M_BR); tick();
      idle(); load_use_rs8(); expect_o("drain_stall", 8'h06, M_BR); tick();
      idle(); halt_req = 1; expect_o("halt", HLT, FULL); tick();
      idle(); halt_req = 1; resume = 1; expect_o("halt_resume", HLT, FULL); tick();
      idle(); expect_c("resumed", NORM, FULL, 4, 5); tick();
      idle(); resume = 1; expect_o("resume_in_run", NORM, FULL); tick();
      idle(); expect_o("run_after_resume", NORM, FULL); tick();

      // reset on the second drain cycle
      idle(); halt_req = 1; expect_o("halt_req2", NORM, FULL); tick();
      idle(); expect_o("drain2_c1", DRN, M_BR); tick();
      rst = 1'b1; expect_o("rst_in_drain", RSTV, FULL); tick();
      rst = 1'b0; expect_c("after_rst", NORM, FULL, 0, 0); tick();
      expect_o("still_run", NORM, FULL); tick();

      tick(); tick();
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: %0d entries left want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
Controller that sequences the five-stage MIPS fetch stage and front-end pipeline registers. It resolves redirect priority between the ID-stage jumps (j/jal/jr) and the EX-stage taken branch, and detects load-use and jr-operand hazards. From these it drives the fetch PC enable, the one-hot redirect strobes, and the IF/ID and ID/EX enable/flush controls. It also provides a halt/drain/resume sequence for debug and syscall stop.

Parameters:
REG_AW, 5, register index width.
DRAIN_CYCLES, 3, bubbles inserted after halt_req before entering HALT; legal range 1..15.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous reset, active-high.
id_rs  in  REG_AW  rs index of the instruction in ID.
id_rt  in  REG_AW  rt index of the instruction in ID.
id_use_rs  in  1  ID instruction reads rs.
id_use_rt  in  1  ID instruction reads rt.
id_jmp  in  1  ID holds j or jal.
id_jr  in  1  ID holds jr.
ex_memread  in  1  EX holds a load.
ex_regwrite  in  1  EX writes a register.
ex_rd  in  REG_AW  EX destination index.
mem_memread  in  1  MEM holds a load.
mem_rd  in  REG_AW  MEM destination index.
ex_branch_taken  in  1  EX branch resolved taken.
halt_req  in  1  request fetch halt (level, sampled).
resume  in  1  leave HALT.
pc_en  out  1  fetch PC update enable.
fe_jmp  out  1  select jump target (j/jal).
fe_jr  out  1  select jr target.
fe_branch  out  1  select branch target.
ifid_en  out  1  IF/ID register load enable.
ifid_flush  out  1  IF/ID register becomes a bubble.
idex_flush  out  1  ID/EX register becomes a bubble.
halted  out  1  FSM in HALT.
stall_cnt  out  32  stall-cycle counter (see optional feature).
flush_cnt  out  32  redirect counter (see optional feature).

Behaviour:
- Registered state only: FSM {RUN, DRAIN, HALT} and drain counter (4 bits). All control outputs are combinational from state and inputs, so control latency is 0 cycles.
- Reset (rst=1 at clock edge): FSM goes to RUN, drain counter to 0, perf counters to 0.
- While rst=1, outputs are pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, fe_*=0, halted=0.
- Hazard terms (a match requires a nonzero index):
  - lu_haz = ex_memread and ((id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd)).
  - jr_haz = id_jr and ((ex_regwrite and id_rs==ex_rd) or (mem_memread and id_rs==mem_rd)).
  - stall = lu_haz or jr_haz.
- RUN, priority highest first:
  1. ex_branch_taken: fe_branch=1, pc_en=1, ifid_flush=1, idex_flush=1. Overrides stall and any ID jump, which is wrong-path.
  2. stall: pc_en=0, ifid_en=0, idex_flush=1, fe_*=0.
  3. id_jmp: fe_jmp=1, pc_en=1, ifid_flush=1 (no delay slot).
  4. id_jr: fe_jr=1, pc_en=1, ifid_flush=1.
  5. Otherwise: pc_en=1, ifid_en=1, all flushes and strobes 0.
- fe_jmp, fe_jr and fe_branch are never asserted together (one-hot or zero).
- Halt sequence:
  - halt_req=1 in RUN: next state DRAIN, counter=DRAIN_CYCLES-1. The current cycle still follows the RUN rules.
  - DRAIN: pc_en=0, ifid_flush=1. ID/EX follows the stall rule. ex_branch_taken still gives fe_branch=1 and pc_en=1 so the target is captured. ID jumps are ignored. Counter decrements each cycle; at 0 the next state is HALT.
  - HALT: halted=1, pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1. resume=1 gives RUN on the next cycle.
  - resume is ignored outside HALT. halt_req is ignored in DRAIN and HALT. halt_req and resume both high in HALT: resume wins.
- rst mid-DRAIN or mid-HALT returns to RUN immediately at that edge.

Optional Feature:
FETCH_HAZARD_CTRL_PERF_EN.
- Defined: stall_cnt increments on every cycle where stall blocks pc_en in RUN. flush_cnt increments on every cycle with any fe_* asserted. Both wrap modulo 2^32 and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package fetch_ctrl_pkg: FSM state typedef (RUN=2'd0, DRAIN=2'd1, HALT=2'd2), REG_AW constant, ZERO_REG=0.
- One natural sub-module, hazard_detect: purely combinational lu_haz/jr_haz/stall, reused later by the forwarding unit.

Test Plan:
- Load-use: ex_memread=1, ex_rd=8, id_rs=8, id_use_rs=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. The next cycle (load in MEM) -> pc_en=1.
- jr after load: ex_memread=1, ex_regwrite=1, ex_rd=31, id_jr=1, id_rs=31 -> two stall cycles, then fe_jr=1, ifid_flush=1. With ex_rd=0 and mem_rd=0 -> no stall.
- Priority: ex_branch_taken=1, id_jmp=1 and lu_haz=1 together -> only fe_branch=1, pc_en=1, ifid_flush=1, idex_flush=1.
- Halt: halt_req pulse in RUN with DRAIN_CYCLES=3 -> 3 DRAIN cycles with pc_en=0, then halted=1. resume=1 -> RUN next cycle with pc_en=1.
- Reset mid-DRAIN: assert rst on 2nd DRAIN cycle -> RUN after the edge, halted=0. Perf build: counters read 0.
- Perf build: 4 stalls + 2 redirects -> stall_cnt=4, flush_cnt=2. Non-perf build: both read 0.
